// File: rtl/sync_filter_pkg.sv
// sync_filter_pkg: shared constants and helpers for the sync_filter_bank slice.
//   cnt_width()        - persistence counter width for a given FILT_CYCLES
//   *_MIN / *_MAX      - legal parameter ranges, checked at elaboration
package sync_filter_pkg;

  localparam int unsigned CHANNELS_MIN    = 1;
  localparam int unsigned STAGES_MIN      = 2;
  localparam int unsigned FILT_CYCLES_MIN = 1;
  localparam int unsigned FILT_CYCLES_MAX = 65536;

  // Counter must hold FILT_CYCLES-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned filt_cycles);
    return (filt_cycles < 2) ? 1 : $clog2(filt_cycles);
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// sync_filter_chan: one input-conditioning channel.
//   clk, rst  - system clock, synchronous active-high reset
//   in_wire   - raw asynchronous input
//   filt_en   - 1: persistence threshold FILT_CYCLES, 0: threshold 1
//   out_wire  - synchronised, filtered level
//   rise/fall - one-cycle strobes on accepted level changes
//   glitch    - one-cycle strobe when a pending change reverted early
module sync_filter_chan
  import sync_filter_pkg::*;
#(
  parameter int unsigned STAGES      = 2,
  parameter int unsigned FILT_CYCLES = 4,
  parameter logic        RST_BIT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_wire,
  input  logic filt_en,
  output logic out_wire,
  output logic rise,
  output logic fall,
  output logic glitch
);

  localparam int unsigned    CW        = cnt_width(FILT_CYCLES);
  localparam logic [CW-1:0]  FILT_LAST = CW'(FILT_CYCLES - 1);

  logic [STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              out_q, out_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              glitch_q, glitch_d;
  logic              sync_lvl;
  logic [CW-1:0]     thresh_last;

  assign sync_lvl    = sync_q[STAGES-1];
  assign thresh_last = filt_en ? FILT_LAST : '0;

  always_comb begin
    sync_d   = {sync_q[STAGES-2:0], in_wire};
    out_d    = out_q;
    cnt_d    = '0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = 1'b0;
    if (sync_lvl == out_q) begin
      glitch_d = (cnt_q != '0);
    end else if (cnt_q >= thresh_last) begin
      // >= rather than == so a threshold lowered mid-count accepts at once
      out_d  = sync_lvl;
      rise_d = sync_lvl;
      fall_d = ~sync_lvl;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= {STAGES{RST_BIT}};
      out_q    <= RST_BIT;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign out_wire = out_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign glitch   = glitch_q;

endmodule

// File: rtl/sync_filter_bank.sv
// sync_filter_bank: CHANNELS independent synchroniser + persistence filters.
//   clk, rst  - system clock, synchronous active-high reset
//   in_wire   - raw asynchronous inputs, one bit per channel
//   filt_en   - shared filter enable (0 = bypass, threshold 1)
//   out_wire  - filtered levels
//   rise/fall/glitch - per-channel one-cycle strobes
module sync_filter_bank
  import sync_filter_pkg::*;
#(
  parameter int unsigned          CHANNELS    = 3,
  parameter int unsigned          STAGES      = 2,
  parameter int unsigned          FILT_CYCLES = 4,
  parameter logic [CHANNELS-1:0]  RST_VAL     = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in_wire,
  input  logic                filt_en,
  output logic [CHANNELS-1:0] out_wire,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] glitch
);

  if (CHANNELS < CHANNELS_MIN) begin : g_bad_channels
    $error("sync_filter_bank: CHANNELS must be >= %0d", CHANNELS_MIN);
  end
  if (STAGES < STAGES_MIN) begin : g_bad_stages
    $error("sync_filter_bank: STAGES must be >= %0d", STAGES_MIN);
  end
  if (FILT_CYCLES < FILT_CYCLES_MIN || FILT_CYCLES > FILT_CYCLES_MAX) begin : g_bad_filt
    $error("sync_filter_bank: FILT_CYCLES must be in %0d..%0d",
           FILT_CYCLES_MIN, FILT_CYCLES_MAX);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    sync_filter_chan #(
      .STAGES      (STAGES),
      .FILT_CYCLES (FILT_CYCLES),
      .RST_BIT     (RST_VAL[i])
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .in_wire  (in_wire[i]),
      .filt_en  (filt_en),
      .out_wire (out_wire[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .glitch   (glitch[i])
    );
  end

endmodule
